// File: rtl/axis_generator_lite.sv
// AXI-Stream incrementing-word packet source with an AXI-Lite control/status slave.
// Bursts of accepted beats are separated by programmable idle gaps; throughput is measured per FREQ_HZ window.
module axis_generator_lite #(
  parameter int unsigned FREQ_HZ             = 250000000,
  parameter int unsigned N_BYTES             = 4,
  parameter int unsigned DEFAULT_PACKET_SIZE = 4096,
  parameter int unsigned DEFAULT_VALID_LIMIT = 4096,
  parameter int unsigned DEFAULT_PAUSE_LIMIT = 0
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [5:0]           awaddr,
  input  logic [2:0]           awprot,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [5:0]           araddr,
  input  logic [2:0]           arprot,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic [N_BYTES*8-1:0] M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic                 M_AXIS_TLAST
);

  localparam int DW = N_BYTES * 8;
  localparam logic [31:0] RST_LAST = (DEFAULT_PACKET_SIZE == 0) ? 32'd0 : 32'(DEFAULT_PACKET_SIZE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_PAUSE} state_t;
  state_t state_reg, state_next;

  logic [1:0]    ctrl_reg;
  logic [31:0]   pkt_size_reg, valid_limit_reg, pause_limit_reg;
  logic          wr_busy_reg;
  logic [3:0]    wr_idx_reg, ar_idx_reg;
  logic [31:0]   wr_data_reg, rd_mux;
  logic [DW-1:0] data_cnt_reg;
  logic [31:0]   beat_idx_reg, burst_cnt_reg, cur_last_reg, pause_cnt_reg;
  logic [31:0]   pkt_count_reg, win_cnt_reg, win_beats_reg, word_speed_reg;
  logic          hs, last_beat, burst_end, soft_rst, enable;
  logic [31:0]   size_last;

  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, wstrb, awaddr[1:0], araddr[1:0]};

  assign awready = wr_busy_reg;
  assign wready  = wr_busy_reg;

  // Write: accept, then commit and respond on the following cycle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_busy_reg     <= 1'b0;
      wr_idx_reg      <= 4'd0;
      wr_data_reg     <= 32'd0;
      bvalid          <= 1'b0;
      bresp           <= 2'b00;
      ctrl_reg        <= 2'b01;
      pkt_size_reg    <= 32'(DEFAULT_PACKET_SIZE);
      valid_limit_reg <= 32'(DEFAULT_VALID_LIMIT);
      pause_limit_reg <= 32'(DEFAULT_PAUSE_LIMIT);
    end else begin
      if (bvalid && bready)
        bvalid <= 1'b0;
      if (wr_busy_reg) begin
        wr_busy_reg <= 1'b0;
        bvalid      <= 1'b1;
        bresp       <= (wr_idx_reg < 4'd4) ? 2'b00 : 2'b10;
        case (wr_idx_reg)
          4'd0:    ctrl_reg        <= wr_data_reg[1:0];
          4'd1:    pkt_size_reg    <= wr_data_reg;
          4'd2:    valid_limit_reg <= wr_data_reg;
          4'd3:    pause_limit_reg <= wr_data_reg;
          default: ;
        endcase
      end else if (awvalid && wvalid && !bvalid) begin
        wr_busy_reg <= 1'b1;
        wr_idx_reg  <= awaddr[5:2];
        wr_data_reg <= wdata;
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (ar_idx_reg)
      4'd0:    rd_mux = {30'd0, ctrl_reg};
      4'd1:    rd_mux = pkt_size_reg;
      4'd2:    rd_mux = valid_limit_reg;
      4'd3:    rd_mux = pause_limit_reg;
      4'd4:    rd_mux = pkt_count_reg;
      4'd5:    rd_mux = word_speed_reg;
      4'd6:    rd_mux = 32'(FREQ_HZ);
      4'd7:    rd_mux = 32'(N_BYTES);
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      arready    <= 1'b0;
      ar_idx_reg <= 4'd0;
      rvalid     <= 1'b0;
      rdata      <= 32'd0;
      rresp      <= 2'b00;
    end else begin
      if (rvalid && rready)
        rvalid <= 1'b0;
      if (arready) begin
        arready <= 1'b0;
        rvalid  <= 1'b1;
        rdata   <= rd_mux;
        rresp   <= (ar_idx_reg < 4'd8) ? 2'b00 : 2'b10;
      end else if (arvalid && !rvalid) begin
        arready    <= 1'b1;
        ar_idx_reg <= araddr[5:2];
      end
    end
  end

  assign M_AXIS_TVALID = (state_reg == ST_SEND);
  assign M_AXIS_TDATA  = data_cnt_reg;
  assign M_AXIS_TLAST  = (state_reg == ST_SEND) && last_beat;

  assign enable    = ctrl_reg[1];
  assign hs        = M_AXIS_TVALID && M_AXIS_TREADY;
  assign last_beat = (beat_idx_reg == cur_last_reg);
  assign size_last = (pkt_size_reg == 32'd0) ? 32'd0 : pkt_size_reg - 32'd1;
  // A stalled beat must complete before the soft reset takes hold.
  assign soft_rst  = ctrl_reg[0] && !(M_AXIS_TVALID && !M_AXIS_TREADY);
  assign burst_end = hs && (valid_limit_reg != 32'd0) && (pause_limit_reg != 32'd0) &&
                     (burst_cnt_reg + 32'd1 >= valid_limit_reg);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (soft_rst) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:  if (enable) state_next = ST_SEND;
        ST_SEND: begin
          if (hs && last_beat && !enable) state_next = ST_IDLE;
          else if (burst_end)             state_next = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (!enable && beat_idx_reg == 32'd0)            state_next = ST_IDLE;
          else if (pause_cnt_reg + 32'd1 >= pause_limit_reg) state_next = ST_SEND;
        end
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      data_cnt_reg   <= '0;
      beat_idx_reg   <= 32'd0;
      burst_cnt_reg  <= 32'd0;
      cur_last_reg   <= RST_LAST;
      pause_cnt_reg  <= 32'd0;
      pkt_count_reg  <= 32'd0;
      win_cnt_reg    <= 32'd0;
      win_beats_reg  <= 32'd0;
      word_speed_reg <= 32'd0;
    end else if (soft_rst) begin
      data_cnt_reg  <= '0;
      beat_idx_reg  <= 32'd0;
      burst_cnt_reg <= 32'd0;
      pause_cnt_reg <= 32'd0;
      pkt_count_reg <= 32'd0;
      win_cnt_reg   <= 32'd0;
      win_beats_reg <= 32'd0;
    end else begin
      if (hs) begin
        data_cnt_reg  <= data_cnt_reg + DW'(1);
        burst_cnt_reg <= burst_end ? 32'd0 : burst_cnt_reg + 32'd1;
        if (last_beat) begin
          beat_idx_reg  <= 32'd0;
          pkt_count_reg <= pkt_count_reg + 32'd1;
          cur_last_reg  <= size_last;
        end else begin
          beat_idx_reg <= beat_idx_reg + 32'd1;
        end
      end else if (state_reg != ST_SEND && beat_idx_reg == 32'd0) begin
        cur_last_reg <= size_last;
      end
      pause_cnt_reg <= (state_reg == ST_PAUSE) ? pause_cnt_reg + 32'd1 : 32'd0;
      // A beat accepted on the wrap cycle still belongs to the closing window.
      if (win_cnt_reg == 32'(FREQ_HZ - 1)) begin
        win_cnt_reg    <= 32'd0;
        word_speed_reg <= win_beats_reg + 32'(hs);
        win_beats_reg  <= 32'd0;
      end else begin
        win_cnt_reg   <= win_cnt_reg + 32'd1;
        win_beats_reg <= win_beats_reg + 32'(hs);
      end
    end
  end

endmodule

// File: tb/tb_axis_generator_lite.sv
// Directed bench for axis_generator_lite: AXI-Lite accesses plus a scoreboard of expected stream beats.
module tb_axis_generator_lite;

  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [5:0]    awaddr = '0;
  logic [2:0]    awprot = '0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = 4'hF;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b1;
  logic [5:0]    araddr = '0;
  logic [2:0]    arprot = '0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready = 1'b1;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;

  axis_generator_lite #(
    .FREQ_HZ(250000000), .N_BYTES(4), .DEFAULT_PACKET_SIZE(4096),
    .DEFAULT_VALID_LIMIT(4096), .DEFAULT_PAUSE_LIMIT(0)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .M_AXIS_TDATA(tdata), .M_AXIS_TVALID(tvalid), .M_AXIS_TREADY(tready), .M_AXIS_TLAST(tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            errors = 0;
  int            checks = 0;
  int            rdy_mode = 0;   // 0: TREADY low, 1: high, 2: random
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // One cycle: drive TREADY at the falling edge, then observe what the next rising edge will accept.
  task automatic step();
    beat_t e;
    @(negedge aclk);
    case (rdy_mode)
      0:       tready = 1'b0;
      1:       tready = 1'b1;
      default: tready = 1'($urandom_range(0, 1));
    endcase
    #1;
    if (prev_stall)
      check("stall_stable", {30'd0, tvalid, tlast, tdata}, {30'd0, 1'b1, prev_last, prev_data});
    if (tvalid && tready) begin
      if (exp_q.size() == 0) begin
        check("sb_beat_expected", 64'd0, 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 64'(tdata), 64'(e.data));
        check("beat_last", 64'(tlast), 64'(e.last));
        $display("beat data=%0d last=%0d", tdata, tlast);
      end
    end
    prev_stall = tvalid && !tready;
    prev_data  = tdata;
    prev_last  = tlast;
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] exp_resp, input string tag);
    int n = 0;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    do begin step(); n++; end while (!awready && n < 50);
    check($sformatf("%s_awready", tag), 64'(awready), 64'd1);
    check($sformatf("%s_wready", tag), 64'(wready), 64'd1);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check($sformatf("%s_bvalid", tag), 64'(bvalid), 64'd1);
    check($sformatf("%s_bresp", tag), 64'(bresp), 64'(exp_resp));
    $display("write addr=0x%0h data=0x%0h bresp=%0d", addr, data, bresp);
    step();
  endtask

  task automatic axi_read(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp, input string tag);
    int n = 0;
    araddr = addr; arvalid = 1'b1;
    do begin step(); n++; end while (!arready && n < 50);
    check($sformatf("%s_arready", tag), 64'(arready), 64'd1);
    step();
    arvalid = 1'b0;
    check($sformatf("%s_rvalid", tag), 64'(rvalid), 64'd1);
    check($sformatf("%s_rdata", tag), 64'(rdata), 64'(exp_data));
    check($sformatf("%s_rresp", tag), 64'(rresp), 64'(exp_resp));
    $display("read addr=0x%0h rdata=0x%0h rresp=%0d", addr, rdata, rresp);
    step();
  endtask

  task automatic wait_drain(input int limit, input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < limit) begin step(); n++; end
    check($sformatf("%s_drained", tag), 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_tvalid(input string tag);
    int n = 0;
    while (!tvalid && n < 20) begin step(); n++; end
    check($sformatf("%s_tvalid_up", tag), 64'(tvalid), 64'd1);
  endtask

  // Soft reset with a stalled beat pending: that beat must still go out, then the stream stops.
  task automatic soft_reset_drain(input logic [DW-1:0] d, input logic l);
    push_beat(d, l);
    rdy_mode = 0;
    axi_write(6'h00, 32'h1, 2'b00, "w_ctrl_srst");
    rdy_mode = 1;
    repeat (4) step();
    check("srst_tvalid_low", 64'(tvalid), 64'd0);
    check("srst_sb_empty", 64'(exp_q.size()), 64'd0);
    rdy_mode = 0;
    axi_read(6'h10, 32'd0, 2'b00, "pkt_count_after_srst");
  endtask

  initial begin
    int vcount;

    // Reset state
    repeat (3) @(negedge aclk);
    #1;
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", 64'(tdata), 64'd0);
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    aresetn = 1'b1;

    axi_read(6'h00, 32'h1, 2'b00, "rd_ctrl");
    axi_read(6'h04, 32'd4096, 2'b00, "rd_pkt_size");
    axi_read(6'h18, 32'd250000000, 2'b00, "rd_freq");
    axi_read(6'h1C, 32'd4, 2'b00, "rd_nbytes");
    vcount = 0;
    repeat (100) begin step(); if (tvalid) vcount++; end
    check("idle_tvalid_cycles", 64'(vcount), 64'd0);

    // Two packets of 4 beats
    axi_write(6'h04, 32'd4, 2'b00, "w_pkt_size");
    for (int i = 0; i < 8; i++) push_beat(DW'(i), (i % 4) == 3);
    rdy_mode = 1;
    axi_write(6'h00, 32'h2, 2'b00, "w_ctrl_en");
    wait_drain(200, "t2");
    rdy_mode = 0;
    step();
    axi_read(6'h10, 32'd2, 2'b00, "pkt_count_2");

    // Burst of 3, pause of 2
    soft_reset_drain(DW'(8), 1'b0);
    axi_write(6'h08, 32'd3, 2'b00, "w_valid_limit");
    axi_write(6'h0C, 32'd2, 2'b00, "w_pause_limit");
    for (int i = 0; i < 9; i++) push_beat(DW'(i), (i % 4) == 3);
    axi_write(6'h00, 32'h2, 2'b00, "w_ctrl_en3");
    wait_tvalid("t3");
    rdy_mode = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("t3_valid_pattern_%0d", i), 64'(tvalid), 64'((i % 5) < 3));
    end
    rdy_mode = 0;
    step();
    check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Random backpressure, 1000 gapless beats
    soft_reset_drain(DW'(9), 1'b0);
    axi_write(6'h08, 32'd0, 2'b00, "w_valid_limit0");
    axi_write(6'h0C, 32'd0, 2'b00, "w_pause_limit0");
    axi_write(6'h00, 32'h2, 2'b00, "w_ctrl_en4");
    for (int i = 0; i < 1000; i++) push_beat(DW'(i), (i % 4) == 3);
    rdy_mode = 2;
    wait_drain(5000, "t4");
    rdy_mode = 0;
    step();

    // Clearing enable mid-packet finishes the packet
    push_beat(DW'(1000), 1'b0);
    rdy_mode = 1;
    step();
    rdy_mode = 0;
    step();
    check("t5_pending_data", 64'(tdata), 64'd1001);
    axi_read(6'h10, 32'd250, 2'b00, "pkt_count_250");
    axi_write(6'h00, 32'h0, 2'b00, "w_ctrl_dis");
    push_beat(DW'(1001), 1'b0);
    push_beat(DW'(1002), 1'b0);
    push_beat(DW'(1003), 1'b1);
    rdy_mode = 1;
    wait_drain(50, "t5");
    repeat (4) step();
    check("t5_tvalid_low", 64'(tvalid), 64'd0);
    axi_read(6'h10, 32'd251, 2'b00, "pkt_count_251");

    // Error responses and asynchronous reset
    axi_read(6'h3C, 32'd0, 2'b10, "rd_unmapped");
    axi_write(6'h10, 32'h1234, 2'b10, "w_ro_pkt_count");
    axi_read(6'h10, 32'd251, 2'b00, "pkt_count_kept");
    rdy_mode = 0;
    axi_write(6'h00, 32'h2, 2'b00, "w_ctrl_en6");
    wait_tvalid("t6");
    @(negedge aclk);
    #3 aresetn = 1'b0;
    #1;
    check("async_rst_tvalid", 64'(tvalid), 64'd0);
    check("async_rst_tdata", 64'(tdata), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
